// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions
// for the sequential execute-stage ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_MOD = 4'd4
   } op_e;

   localparam int FLAG_OVF   = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_SIGN  = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_DONE
   } state_e;

   function automatic logic [3:0] pack_flags(
      input logic ovf,
      input logic carry,
      input logic zero,
      input logic sign
   );
      logic [3:0] f;
      f             = '0;
      f[FLAG_OVF]   = ovf;
      f[FLAG_CARRY] = carry;
      f[FLAG_ZERO]  = zero;
      f[FLAG_SIGN]  = sign;
      return f;
   endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// quot_o/rem_o carry the post-step values so the last step can be captured.
module alu_div_iter
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [N-1:0] dividend_i,
   input  logic [N-1:0] divisor_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] quot_o,
   output logic [N-1:0] rem_o
);

   localparam int CW = $clog2(N + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N:0]    shl, diff;
   logic          ge;

   // dvd_q shifts dividend bits out the top and quotient bits in the bottom
   assign shl    = {rem_q, dvd_q[N-1]};
   assign diff   = shl - {1'b0, dvs_q};
   assign ge     = ~diff[N];
   assign quot_o = {dvd_q[N-2:0], ge};
   assign rem_o  = ge ? diff[N-1:0] : shl[N-1:0];
   assign busy_o = run_q;
   assign done_o = run_q && (cnt_q == CW'(1));

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      if (start_i) begin
         cnt_d = CW'(N);
         run_d = 1'b1;
         dvd_d = dividend_i;
         dvs_d = divisor_i;
         rem_d = '0;
      end else if (run_q) begin
         cnt_d = cnt_q - CW'(1);
         dvd_d = quot_o;
         rem_d = rem_o;
         if (cnt_q == CW'(1)) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked execute-stage ALU: single-cycle add/sub/mul,
// iterative div/mod through alu_div_iter.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   operacion,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] resultado,
   output logic [3:0]   flagsResult
);

   state_e       state_q, state_d;
   logic [N-1:0] res_q, res_d;
   logic [3:0]   flg_q, flg_d;
   logic         is_mod_q, is_mod_d;

   logic [N:0]     sum, dif;
   logic [2*N-1:0] prod;
   logic [N-1:0]   alu_res, div_res;
   logic [3:0]     alu_flg;
   logic           alu_ovf, alu_cy, is_divop;

   logic         div_start, div_busy, div_done;
   logic [N-1:0] div_quot, div_rem;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign dif  = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
   assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};

   assign is_divop = (operacion == OP_DIV) || (operacion == OP_MOD);

   // Div/mod arms only reach the result register when b is zero
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_cy  = 1'b0;
      unique case (operacion)
         OP_ADD: begin
            alu_res = sum[N-1:0];
            alu_cy  = sum[N];
            alu_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
         end
         OP_SUB: begin
            alu_res = dif[N-1:0];
            alu_cy  = dif[N];
            alu_ovf = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
         end
         OP_MUL: begin
            alu_res = prod[N-1:0];
            alu_ovf = |prod[2*N-1:N];
         end
         OP_DIV: begin
            alu_res = '1;
            alu_ovf = 1'b1;
         end
         OP_MOD: begin
            alu_res = a;
            alu_ovf = 1'b1;
         end
         default: ;
      endcase
      alu_flg = pack_flags(alu_ovf, alu_cy,
                           alu_res == '0, alu_res[N-1]);
   end

   assign div_res = is_mod_q ? div_rem : div_quot;

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      flg_d     = flg_q;
      is_mod_d  = is_mod_q;
      div_start = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_divop && (b != '0)) begin
                  div_start = 1'b1;
                  is_mod_d  = (operacion == OP_MOD);
                  state_d   = S_DIV;
               end else begin
                  res_d   = alu_res;
                  flg_d   = alu_flg;
                  state_d = S_DONE;
               end
            end
         end
         S_DIV: begin
            if (div_busy && div_done) begin
               res_d   = div_res;
               flg_d   = pack_flags(1'b0, 1'b0,
                                    div_res == '0, div_res[N-1]);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         res_q    <= '0;
         flg_q    <= '0;
         is_mod_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         res_q    <= res_d;
         flg_q    <= flg_d;
         is_mod_q <= is_mod_d;
      end
   end

   alu_div_iter #(.N(N)) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (a),
      .divisor_i  (b),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .rem_o      (div_rem)
   );

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign resultado   = res_q;
   assign flagsResult = flg_q;

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Sequential, handshaked ALU responder for the CPU datapath. Accepts one operation request (operands plus 4-bit opcode) on a valid/ready input channel and returns the result and four status flags on a valid/ready output channel. Add, subtract and multiply complete in one cycle; divide and modulo use an iterative restoring divider taking N cycles. Sits between the decode/issue stage and writeback as the execute-stage arithmetic engine.

## Interface
- N, default 32, operand/result width (N ≥ 4).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- a  in  N  operand A.
- b  in  N  operand B.
- operacion  in  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod; 5–15 reserved.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- resultado  out  N  result.
- flagsResult  out  4  [0] overflow, [1] carry, [2] zero, [3] sign.

## Operation
- Request accepted on a cycle with in_valid && in_ready; a, b, operacion captured.
- in_ready = 1 only in IDLE.
- States: IDLE, DIV, DONE.
  - IDLE + accept, op 0/1/2/reserved → DONE; result and flags registered that edge.
  - IDLE + accept, op 3/4 with b ≠ 0 → DIV; iteration counter loaded with N.
  - IDLE + accept, op 3/4 with b = 0 → DONE directly.
  - DIV: one quotient bit per cycle, MSB first; counter reaching 0 → DONE, result registered.
  - DONE: out_valid = 1; out_ready = 1 → IDLE. Otherwise hold resultado/flagsResult stable.
- Arithmetic (unsigned operand interpretation except where noted):
  - add: resultado = (a + b) mod 2^N; carry = bit N of the sum; overflow = signed overflow (same operand signs, result sign differs).
  - sub: computed as a + ~b + 1; carry = 1 when no borrow (a ≥ b unsigned); overflow = signed overflow.
  - mul: resultado = low N bits of the 2N product; overflow = 1 if high N bits nonzero; carry = 0.
  - div: quotient. mod: remainder. carry = 0, overflow = 0.
  - div by zero: quotient = all ones, remainder = a, overflow = 1.
  - reserved: resultado = 0, flags = {sign 0, zero 1, carry 0, overflow 0}.
  - zero = (resultado == 0); sign = resultado[N-1]; both apply to every op.

## Timing
- Reset: state IDLE, in_ready = 1 (once rst low), out_valid = 0, resultado = 0, flagsResult = 0, counter = 0.
- rst asserted in any state (including mid-DIV or DONE with a pending result) aborts; pending result discarded, no out_valid afterwards.
- Latency, accept edge to out_valid high: 1 cycle for add/sub/mul/reserved/div-by-zero; N+1 cycles for div/mod.
- Minimum spacing between accepts: 2 cycles (accept → DONE → IDLE). No overlap; in_ready low in DIV and DONE.
- in_valid while in_ready = 0 is ignored; no request queuing.
- Outputs registered; no combinational path from in_* to out_*. out_ready → in_ready path is through state only.

## Structure
- Package alu_pkg: opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD), flag bit indices (FLAG_OVF = 0, FLAG_CARRY = 1, FLAG_ZERO = 2, FLAG_SIGN = 3), state enum.
- Sub-module alu_div_iter: start/busy/done restoring divider producing quotient and remainder; alu_seq_unit owns the handshake FSM and the single-cycle ops.

## Test plan
- add a=10 b=20 → resultado 30, flags 0000, out_valid 1 cycle after accept.
- sub a=10 b=30 → 0xFFFFFFEC, sign 1, carry 0, zero 0, overflow 0; sub a=50 b=25 → 25, carry 1.
- mul a=5 b=0 → 0, zero 1; mul a=0x10000 b=0x10000 → 0, overflow 1, zero 1.
- div a=25 b=5 → 5 after 33 cycles; mod a=30 b=7 → 2; div a=7 b=0 → 0xFFFFFFFF, overflow 1, 1-cycle latency.
- add a=-15 b=-20 → 0xFFFFFFDD, carry 1, sign 1, overflow 0; add 0x7FFFFFFF+1 → overflow 1, sign 1.
- Hold out_ready low 5 cycles: resultado/flags stable, in_ready 0; assert rst mid-DIV → out_valid stays 0, in_ready 1 next cycle.
